// File: rtl/debounce_defs.sv
// Shared encodings and defaults for the push-button debouncer and its helpers.
// State codes are fixed so that bit 0 doubles as "heading towards / at high".
package debounce_defs;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT           = 16;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } deb_state_t;

  function automatic logic is_wait_state(input deb_state_t st);
    return (st == WAIT_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both stages clear to 0 on
// synchronous reset. WIDTH lets it carry independent single-bit signals.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// Bouncing button input -> synchroniser -> counter-qualified 4-state FSM -> stable level.
// Optional aborted-transition counter enabled by defining DEBOUNCE_BOUNCE_CNT_EN.
module button_debouncer
  import debounce_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  output logic       level,
  output logic       busy
`ifdef DEBOUNCE_BOUNCE_CNT_EN
  ,
  output logic [7:0] bounce_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s2;
  logic             w_abort;
  deb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_busy;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (raw_in),
    .o_sync  (w_s2)
  );

  // A WAIT state that sees the input fall back to the current level gives up
  assign w_abort = ((r_state == WAIT_HIGH) && !w_s2) ||
                   ((r_state == WAIT_LOW)  &&  w_s2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE_LOW: begin
          if (w_s2) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_ONE;
            r_busy  <= is_wait_state(WAIT_HIGH);
          end else begin
            r_cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!w_s2) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= is_wait_state(IDLE_LOW);
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_HIGH;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= is_wait_state(IDLE_HIGH);
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!w_s2) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_ONE;
            r_busy  <= is_wait_state(WAIT_LOW);
          end else begin
            r_cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (w_s2) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_busy  <= is_wait_state(IDLE_HIGH);
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_LOW;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= is_wait_state(IDLE_LOW);
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign level = r_level;
  assign busy  = r_busy;

`ifdef DEBOUNCE_BOUNCE_CNT_EN
  logic [7:0] r_bounce_cnt;

  // Saturating count of aborted qualifications; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bounce_cnt <= 8'h00;
    end else if (w_abort && (r_bounce_cnt != 8'hFF)) begin
      r_bounce_cnt <= r_bounce_cnt + 8'h01;
    end else begin
      r_bounce_cnt <= r_bounce_cnt;
    end
  end

  assign bounce_count = r_bounce_cnt;
`else
  logic w_abort_unused;
  assign w_abort_unused = w_abort;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with DEBOUNCE_CYCLES=4.
// bounce_count checks are compiled in only when DEBOUNCE_BOUNCE_CNT_EN is defined.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic raw_in;
  logic level;
  logic busy;
`ifdef DEBOUNCE_BOUNCE_CNT_EN
  logic [7:0] bounce_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_in       (raw_in),
    .level        (level),
    .busy         (busy)
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    ,
    .bounce_count (bounce_count)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b1;
    raw_in = 1'b0;
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    raw_in = 1'b1;
    tick();
    n_checks++;
    if (level !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_level: got %0b want 0", level);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %0b want 0", busy);
    end
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    n_checks++;
    if (bounce_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_bounce: got %0d want 0", bounce_count);
    end
`endif
    reset  = 1'b0;
    raw_in = 1'b0;
  endtask

  task automatic test_rise;
    logic exp_level;
    logic exp_busy;
    do_reset();
    raw_in = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_level = (e >= 5);
      exp_busy  = (e >= 2) && (e <= 4);
      n_checks++;
      if (level !== exp_level) begin
        n_fail++;
        $display("FAIL rise_level E0+%0d: got %0b want %0b", e, level, exp_level);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rise_busy E0+%0d: got %0b want %0b", e, busy, exp_busy);
      end
    end
  endtask

  task automatic test_bounce;
    logic exp_busy;
    do_reset();
    raw_in = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tick();
      if (e == 1) raw_in = 1'b0;
      exp_busy = (e == 2) || (e == 3);
      n_checks++;
      if (level !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_level E0+%0d: got %0b want 0", e, level);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL bounce_busy E0+%0d: got %0b want %0b", e, busy, exp_busy);
      end
    end
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    n_checks++;
    if (bounce_count !== 8'd1) begin
      n_fail++;
      $display("FAIL bounce_count_1: got %0d want 1", bounce_count);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_level;
    logic exp_busy;
    do_reset();
    // edges 0..3 sample the chatter, edge 4 is the first steady-1 edge
    for (int i = 0; i < 14; i++) begin
      raw_in = (i < 4) ? pat[i] : 1'b1;
      tick();
      exp_level = (i >= 9);
      exp_busy  = (i == 2) || (i == 4) || ((i >= 6) && (i <= 8));
      n_checks++;
      if (level !== exp_level) begin
        n_fail++;
        $display("FAIL b2b_level edge%0d: got %0b want %0b", i, level, exp_level);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL b2b_busy edge%0d: got %0b want %0b", i, busy, exp_busy);
      end
    end
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    n_checks++;
    if (bounce_count !== 8'd2) begin
      n_fail++;
      $display("FAIL b2b_bounce_count: got %0d want 2", bounce_count);
    end
`endif
  endtask

  task automatic test_reset_mid_wait;
    logic exp_level;
    logic exp_busy;
    do_reset();
    raw_in = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre_busy: got %0b want 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (level !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_level: got %0b want 0", level);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_busy: got %0b want 0", busy);
    end
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    n_checks++;
    if (bounce_count !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_bounce: got %0d want 0", bounce_count);
    end
`endif
    for (int e = 0; e < 8; e++) begin
      tick();
      exp_level = (e >= 5);
      exp_busy  = (e >= 2) && (e <= 4);
      n_checks++;
      if (level !== exp_level) begin
        n_fail++;
        $display("FAIL midreset_requal_level R+%0d: got %0b want %0b", e, level, exp_level);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL midreset_requal_busy R+%0d: got %0b want %0b", e, busy, exp_busy);
      end
    end
  endtask

  task automatic test_fall_and_pulse;
    logic exp_level;
    logic exp_busy;
    logic prev;
    int   pulses;
    logic seq [29] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                       1'b0, 1'b1, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    raw_in = 1'b1;
    for (int e = 0; e < 8; e++) tick();
    n_checks++;
    if (level !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_pre_level: got %0b want 1", level);
    end
    raw_in = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp_level = (e < 5);
      exp_busy  = (e >= 2) && (e <= 4);
      n_checks++;
      if (level !== exp_level) begin
        n_fail++;
        $display("FAIL fall_level E0+%0d: got %0b want %0b", e, level, exp_level);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL fall_busy E0+%0d: got %0b want %0b", e, busy, exp_busy);
      end
    end
    // rising-edge detector standing in for the downstream level-to-pulse stage
    prev   = level;
    pulses = 0;
    for (int i = 0; i < 29; i++) begin
      raw_in = seq[i];
      tick();
      if (level && !prev) pulses++;
      prev = level;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL chain_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if (level !== 1'b0) begin
      n_fail++;
      $display("FAIL chain_final_level: got %0b want 0", level);
    end
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 1'b0;
    test_reset();
    test_rise();
    test_bounce();
    test_back_to_back();
    test_reset_mid_wait();
    test_fall_and_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
